mat_mem_arbiter: RTL and testbench

- Shares one single-port synchronous matrix RAM among three requesters: 0 = loader (writes input matrices), 1 = multiply sequencer (reads operands, writes results), 2 = output drain (reads results for serial shift-out).
- Arbitration is round-robin with bounded burst lock.
- Drives the RAM command port and returns read data with a per-requester valid pulse.
- Sits between the matrix-multiply control path and each matrix memory instance; one instance per memory.

---
 rtl/mat_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mat_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous matrix RAM between
// the loader, the multiply sequencer and the output drain, with bounded burst lock.
module mat_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAXBURST = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          lock2,
  input  logic          we0,
  input  logic          we1,
  input  logic          we2,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic [DW-1:0] wdata2,
  output logic          gnt0,
  output logic          gnt1,
  output logic          gnt2,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          rvalid2,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int            CW        = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAXBURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        r_state;
  logic [2:0]    r_gnt;
  logic [1:0]    r_owner;
  logic [1:0]    r_last;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_rvalid;

  logic [2:0]    w_req;
  logic [2:0]    w_we;
  logic          w_any;
  logic          w_access;
  logic          w_release;
  logic          w_own_we;
  logic          w_own_lock;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [1:0]    w_from;
  logic [1:0]    w_win;

  // First requester found searching cyclically from the one after 'from'.
  function automatic logic [1:0] rr_next(input logic [2:0] req, input logic [1:0] from);
    logic [1:0] idx;
    logic [1:0] c;
    idx = from;
    for (int i = 2; i >= 0; i--) begin
      c = 2'((int'(from) + 1 + i) % 3);
      if (req[c]) idx = c;
    end
    return idx;
  endfunction

  assign w_req = {req2, req1, req0};
  assign w_we  = {we2, we1, we0};
  assign w_any = |w_req;

  always_comb begin
    w_addr     = addr2;
    w_wdata    = wdata2;
    w_own_we   = we2;
    w_own_lock = lock2;
    case (r_owner)
      2'd0: begin
        w_addr     = addr0;
        w_wdata    = wdata0;
        w_own_we   = we0;
        w_own_lock = lock0;
      end
      2'd1: begin
        w_addr     = addr1;
        w_wdata    = wdata1;
        w_own_we   = we1;
        w_own_lock = lock1;
      end
      default: ;
    endcase
  end

  // An owner with its request dropped gets no access and always releases.
  assign w_access  = |(r_gnt & w_req);
  assign w_release = !w_access || !w_own_lock || (r_cnt == LAST_BEAT);
  assign w_from    = (r_state == GRANT) ? r_owner : r_last;
  assign w_win     = rr_next(w_req, w_from);

  assign mem_en    = w_access;
  assign mem_we    = w_access & w_own_we;
  assign mem_addr  = w_access ? w_addr : '0;
  assign mem_wdata = w_access ? w_wdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_owner  <= 2'd2;
      r_last   <= 2'd2;
      r_cnt    <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= r_gnt & w_req & ~w_we;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= GRANT;
            r_gnt   <= 3'b001 << w_win;
            r_owner <= w_win;
            r_cnt   <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_last <= r_owner;
            r_cnt  <= '0;
            if (w_any) begin
              r_gnt   <= 3'b001 << w_win;
              r_owner <= w_win;
            end else begin
              r_gnt   <= '0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0    = r_gnt[0];
  assign gnt1    = r_gnt[1];
  assign gnt2    = r_gnt[2];
  assign busy    = |r_gnt;
  assign rvalid0 = r_rvalid[0];
  assign rvalid1 = r_rvalid[1];
  assign rvalid2 = r_rvalid[2];
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mat_mem_arbiter.sv
// Bench for mat_mem_arbiter: queue-driven requesters, a RAM model and a
// transaction-level reference of the arbitration rules.
module tb_mat_mem_arbiter;

  localparam int MAXBURST = 9;

  typedef struct packed {
    logic        we;
    logic        lock;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req_v, lock_v, we_v;
  logic [7:0]  addr_v  [3];
  logic [15:0] wdata_v [3];
  logic        gnt0, gnt1, gnt2, rvalid0, rvalid1, rvalid2;
  logic [15:0] rdata;
  logic        mem_en, mem_we, busy;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] ram [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  cmd_t q0[$], q1[$], q2[$];
  logic [15:0] shadow [256];
  int m_owner, m_last, m_cnt, m_rv, m_acc;
  logic [15:0] m_rdata;
  int n_checks = 0;
  int n_fail   = 0;

  mat_mem_arbiter #(.AW(8), .DW(16), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rst(rst),
    .req0(req_v[0]), .req1(req_v[1]), .req2(req_v[2]),
    .lock0(lock_v[0]), .lock1(lock_v[1]), .lock2(lock_v[2]),
    .we0(we_v[0]), .we1(we_v[1]), .we2(we_v[2]),
    .addr0(addr_v[0]), .addr1(addr_v[1]), .addr2(addr_v[2]),
    .wdata0(wdata_v[0]), .wdata1(wdata_v[1]), .wdata2(wdata_v[2]),
    .gnt0(gnt0), .gnt1(gnt1), .gnt2(gnt2),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rvalid2(rvalid2),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, one-cycle read latency, with a preload path.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int x);
    case (x)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int x, input logic we, input logic lk,
                      input logic [7:0] a, input logic [15:0] d);
    cmd_t c;
    c.we = we; c.lock = lk; c.addr = a; c.wdata = d;
    case (x)
      0:       q0.push_back(c);
      1:       q1.push_back(c);
      default: q2.push_back(c);
    endcase
  endtask

  task automatic apply_inputs();
    cmd_t c;
    for (int x = 0; x < 3; x++) begin
      c = '0;
      if (qsize(x) > 0) begin
        case (x)
          0:       c = q0[0];
          1:       c = q1[0];
          default: c = q2[0];
        endcase
      end
      req_v[x]   = (qsize(x) > 0);
      we_v[x]    = c.we;
      lock_v[x]  = c.lock;
      addr_v[x]  = c.addr;
      wdata_v[x] = c.wdata;
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int from);
    for (int k = 1; k <= 3; k++) begin
      int c = (from + k) % 3;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Compare the current cycle against the reference, then advance the reference.
  task automatic check_neg();
    int   o;
    logic acc;
    @(negedge clk);
    o   = m_owner;
    acc = (o >= 0) ? req_v[o] : 1'b0;
    chk("gnt0", 32'(gnt0), 32'(o == 0));
    chk("gnt1", 32'(gnt1), 32'(o == 1));
    chk("gnt2", 32'(gnt2), 32'(o == 2));
    chk("busy", 32'(busy), 32'(o >= 0));
    chk("mem_en", 32'(mem_en), 32'(acc));
    if (acc) begin
      chk("mem_we", 32'(mem_we), 32'(we_v[o]));
      chk("mem_addr", 32'(mem_addr), 32'(addr_v[o]));
      chk("mem_wdata", 32'(mem_wdata), 32'(wdata_v[o]));
    end else begin
      chk("mem_we_idle", 32'(mem_we), 32'd0);
      chk("mem_addr_idle", 32'(mem_addr), 32'd0);
    end
    chk("rvalid0", 32'(rvalid0), 32'(m_rv == 0));
    chk("rvalid1", 32'(rvalid1), 32'(m_rv == 1));
    chk("rvalid2", 32'(rvalid2), 32'(m_rv == 2));
    if (m_rv >= 0) chk("rdata", 32'(rdata), 32'(m_rdata));

    m_acc = acc ? o : -1;
    if (acc && !we_v[o]) begin
      m_rv    = o;
      m_rdata = shadow[addr_v[o]];
    end else begin
      m_rv = -1;
    end
    if (acc && we_v[o]) shadow[addr_v[o]] = wdata_v[o];

    if (o < 0) begin
      if (|req_v) begin
        m_owner = pick(req_v, m_last);
        m_cnt   = 0;
      end
    end else if (!req_v[o] || !lock_v[o] || m_cnt == MAXBURST - 1) begin
      m_last  = o;
      m_owner = pick(req_v, o);
      m_cnt   = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic adv_pos();
    @(posedge clk);
    #1;
    case (m_acc)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      2: void'(q2.pop_front());
      default: ;
    endcase
    m_acc = -1;
    apply_inputs();
  endtask

  task automatic cycle();
    check_neg();
    adv_pos();
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    #1;
    m_owner = -1; m_last = 2; m_cnt = 0; m_rv = -1; m_acc = -1;
    q0.delete(); q1.delete(); q2.delete();
    apply_inputs();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int   len;
    logic lk;
    rst = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    m_owner = -1; m_last = 2; m_cnt = 0; m_rv = -1; m_acc = -1; m_rdata = '0;
    apply_inputs();

    @(posedge clk); #1;
    pl_en = 1'b1;
    for (int a = 0; a < 256; a++) begin
      pl_addr   = 8'(a);
      pl_data   = (a == 5) ? 16'h00AA : 16'($urandom());
      shadow[a] = pl_data;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;

    chk("rst_gnt", 32'({gnt2, gnt1, gnt0}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rvalid", 32'({rvalid2, rvalid1, rvalid0}), 32'd0);
    release_reset();

    // Single read of RAM[5]
    push(1, 1'b0, 1'b0, 8'h05, 16'h0000);
    apply_inputs();
    cycle();
    check_neg();
    chk("rd_gnt1", 32'(gnt1), 32'd1);
    chk("rd_en", 32'(mem_en), 32'd1);
    chk("rd_addr", 32'(mem_addr), 32'h05);
    adv_pos();
    check_neg();
    chk("rd_rvalid1", 32'(rvalid1), 32'd1);
    chk("rd_data", 32'(rdata), 32'h00AA);
    adv_pos();
    repeat (3) cycle();

    // Locked write burst longer than MAXBURST
    for (int k = 0; k < 12; k++) push(0, 1'b1, 1'b1, 8'(k), 16'($urandom()));
    apply_inputs();
    cycle();
    for (int k = 0; k < MAXBURST; k++) begin
      check_neg();
      chk("bu_gnt0", 32'(gnt0), 32'd1);
      chk("bu_we", 32'(mem_we), 32'd1);
      chk("bu_addr", 32'(mem_addr), 32'(k));
      adv_pos();
    end
    check_neg();
    chk("bu_regrant", 32'(gnt0), 32'd1);
    chk("bu_addr9", 32'(mem_addr), 32'd9);
    adv_pos();
    repeat (5) cycle();

    // Round-robin from reset, single accesses
    assert_reset();
    release_reset();
    for (int x = 0; x < 3; x++)
      repeat (2) push(x, 1'b0, 1'b0, 8'($urandom_range(0, 255)), 16'h0);
    apply_inputs();
    cycle();
    for (int k = 0; k < 6; k++) begin
      check_neg();
      chk("rr_gnt", 32'({gnt2, gnt1, gnt0}), 32'(1 << (k % 3)));
      chk("rr_en", 32'(mem_en), 32'd1);
      adv_pos();
    end
    repeat (3) cycle();

    // Early release of a locked read burst with requester 0 waiting
    push(2, 1'b0, 1'b1, 8'h10, 16'h0);
    push(2, 1'b0, 1'b1, 8'h11, 16'h0);
    push(2, 1'b0, 1'b0, 8'h12, 16'h0);
    apply_inputs();
    cycle();
    push(0, 1'b0, 1'b0, 8'h20, 16'h0);
    apply_inputs();
    for (int k = 0; k < 3; k++) begin
      check_neg();
      chk("er_gnt2", 32'(gnt2), 32'd1);
      adv_pos();
    end
    check_neg();
    chk("er_gnt0", 32'(gnt0), 32'd1);
    chk("er_rvalid2", 32'(rvalid2), 32'd1);
    adv_pos();
    repeat (3) cycle();

    // Reset during the 4th access of a locked read burst
    for (int k = 0; k < 6; k++) push(1, 1'b0, 1'b1, 8'(8'h30 + k), 16'h0);
    apply_inputs();
    cycle();
    for (int k = 0; k < 3; k++) cycle();
    check_neg();
    chk("rb_rvalid1_pre", 32'(rvalid1), 32'd1);
    #2;
    assert_reset();
    chk("rb_gnt1", 32'(gnt1), 32'd0);
    chk("rb_mem_en", 32'(mem_en), 32'd0);
    chk("rb_rvalid1", 32'(rvalid1), 32'd0);
    chk("rb_busy", 32'(busy), 32'd0);
    release_reset();
    push(0, 1'b0, 1'b0, 8'h40, 16'h0);
    push(1, 1'b0, 1'b0, 8'h41, 16'h0);
    apply_inputs();
    cycle();
    check_neg();
    chk("rb_gnt0_first", 32'(gnt0), 32'd1);
    adv_pos();
    repeat (4) cycle();

    // Idle for 20 cycles
    for (int k = 0; k < 20; k++) begin
      check_neg();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_en", 32'(mem_en), 32'd0);
      adv_pos();
    end

    // Randomized traffic
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int x = 0; x < 3; x++) begin
        if (qsize(x) == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 12);
          lk  = 1'($urandom_range(0, 1));
          for (int k = 0; k < len; k++)
            push(x, 1'($urandom_range(0, 1)), lk, 8'($urandom_range(0, 255)), 16'($urandom()));
        end
      end
      apply_inputs();
      cycle();
    end
    for (int k = 0; k < 200 && (qsize(0) + qsize(1) + qsize(2)) > 0; k++) cycle();
    chk("drain_done", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);
    repeat (4) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
